modexp_seq: RTL and testbench
=============================

# modexp_seq

Parametrised sequential modular exponentiator computing c = message^e_key mod n. It is the WIDTH-generic successor of the fixed 128-bit RSA encryptor. Compared with that block it:
- captures its operands on a handshake;
- skips leading zero exponent bits;
- uses a single interleaved modular multiplier instead of a separate multiplier and divider;
- reports invalid operands.

It sits between the key/message register file and the cipher output buffer, and serves both encryption and decryption.

## Interface
- WIDTH, 128, operand width in bits (≥4). Applies to message, e_key, n and c.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request. Accepted only in the cycle where start && ready.
- ready  out  1  high in IDLE. Reset value 1.
- message  in  WIDTH  base. Must be < n.
- e_key  in  WIDTH  exponent.
- n  in  WIDTH  modulus. Must be ≠ 0.
- c  out  WIDTH  result. Reset value 0. Holds its value until the next done.
- done  out  1  one-cycle pulse when c and err are updated. Reset value 0.
- err  out  1  valid with done. 1 means invalid operands. Reset value 0. Holds its value until the next done.

## Operation
- States: IDLE, LOAD, OP_GO, OP_WAIT, FIN.
- IDLE: ready=1. On accept, register message, e_key and n into internal copies, then go to LOAD. Inputs may change freely after the accept cycle.
- LOAD:
  - Set bad = (n==0) || (message>=n).
  - Set k = index of the MSB of e that is 1 (priority encoder).
  - Set r = message.
  - Set bit pointer i = k-1.
  - Set the pending op to SQ.
  - Go to FIN if any of: bad; e==0, which gives r = 1 mod n (so 0 when n==1); e==1, which gives r = message. Otherwise go to OP_GO.
- OP_GO: pulse mm_start with operands (r,r) for SQ or (r,message) for MUL. Go to OP_WAIT.
- OP_WAIT: on mm_done, latch r = product, then:
  - If the op was SQ and e[i]==1, the next op is MUL.
  - Otherwise, if i==0, go to FIN.
  - Otherwise decrement i and the next op is SQ.
  - When continuing, go to OP_GO.
- FIN:
  - c = bad ? 0 : r.
  - err = bad.
  - Pulse done, then go to IDLE.
- start while not ready is ignored. There is no queueing.
- Assertion of reset_n low at any state aborts immediately. All outputs return to their reset values and the partial result is discarded.
- Arithmetic: all intermediate values are < n, so WIDTH bits are enough. Internal accumulators are WIDTH+2 bits wide to absorb 2r+a before reduction. No width truncation is allowed anywhere else.

## Timing
- Sub-module mod_mult_seq (interleaved, MSB-first): per iteration, r' = 2r + (b[j] ? a : 0), followed by up to two conditional subtractions of n. It runs one iteration per cycle for WIDTH cycles.
- mm_start in cycle s gives mm_done and the product in cycle s+WIDTH+1.
- Each op (SQ or MUL) occupies WIDTH+2 cycles, counted from OP_GO to the next OP_GO.
- Let the accept cycle be 0. N = k + popcount(e[k-1:0]) ops.
- done is high in cycle 2 + N·(WIDTH+2).
- Error, e==0 and e==1 cases complete with done high in cycle 2.
- ready goes low in cycle 1 and returns high in the cycle after done. Back-to-back accept is possible in that cycle.

## Structure
- Package rsa_pkg contains:
  - the state enum for modexp_seq;
  - the op enum (OP_SQ, OP_MUL);
  - function modexp_latency(width, e), used by both RTL assertions and the bench.
- Sub-module mod_mult_seq #(WIDTH) has ports clk, reset_n, start, a, b, n, p, done. Its contract requires a, b < n. It contains its own bit counter and 2-state FSM.
- Expected size: about 150 lines for the top FSM plus about 90 lines for the multiplier.

## Test plan
- WIDTH=16, message=4, e_key=13, n=497 -> c=445, err=0. N=5, so done is high at cycle 92.
- WIDTH=16, n=3233: message=65, e_key=17 -> c=2790 at cycle 2+5·18=92. Then message=2790, e_key=2753 -> c=65.
- WIDTH=16, edge cases:
  - e_key=0, n=497 -> c=1 at cycle 2.
  - e_key=0, n=1, message=0 -> c=0.
  - e_key=1, message=7 -> c=7 at cycle 2.
- Errors: message=500 with n=497 -> err=1 and c=0 at cycle 2. Then n=0 -> err=1. Then a valid request -> err returns to 0.
- Handshake and reset:
  - start held high during a run -> ignored, result unchanged.
  - Input change after accept -> no effect on the result.
  - reset_n low in the middle of OP_WAIT -> ready=1, done=0, c=0 immediately; the next request completes correctly.
- WIDTH=128: random 2^127 < n < 2^128 with random message and e, checked against a bench big-integer model. done cycle must equal modexp_latency.

Source files
------------

// File: rtl/modexp_seq_pkg.sv
// Shared types and helpers for the modular exponentiator: FSM/op encodings
// and the cycle-exact latency model.
package rsa_pkg;

    localparam int MAX_WIDTH = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_OP_GO,
        S_OP_WAIT,
        S_FIN
    } modexp_state_e;

    typedef enum logic {
        OP_SQ,
        OP_MUL
    } op_e;

    typedef enum logic {
        MM_IDLE,
        MM_BUSY
    } mm_state_e;

    // Cycle (accept = 0) in which done is high for a valid request with exponent e.
    function automatic int modexp_latency(input int width, input logic [MAX_WIDTH-1:0] e);
        int k;
        int pop;
        k   = 0;
        pop = 0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (e[i]) begin
                k = i;
                pop++;
            end
        end
        if (k == 0) return 2;
        return 2 + (k + pop - 1) * (width + 2);
    endfunction

endpackage

// File: rtl/modexp_seq_if.sv
// Request/response bundle between the register file, the exponentiator and
// the cipher output buffer.
interface modexp_seq_if #(parameter int WIDTH = 128);

    logic             start;
    logic             ready;
    logic [WIDTH-1:0] message;
    logic [WIDTH-1:0] e_key;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] c;
    logic             done;
    logic             err;

    modport master (
        output start, message, e_key, n,
        input  ready, c, done, err
    );

    modport slave (
        input  start, message, e_key, n,
        output ready, c, done, err
    );

endinterface

// File: rtl/modexp_seq_mod_mult.sv
// Interleaved MSB-first modular multiplier: p = a*b mod n in WIDTH iterations,
// done pulses WIDTH+1 cycles after start. Requires a, b < n.
module mod_mult_seq
    import rsa_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] p,
    output logic             done
);

    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH);

    mm_state_e        state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic             done_q;

    logic [AW-1:0]    sum;
    logic [AW-1:0]    sub1;
    logic [AW-1:0]    nExt;
    logic [WIDTH-1:0] acc_d;

    // 2*acc + a stays below 3n, so two conditional subtractions fully reduce it.
    always_comb begin
        nExt  = AW'(n_q);
        sum   = AW'({acc_q, 1'b0}) + (b_q[cnt_q] ? AW'(a_q) : '0);
        sub1  = (sum >= nExt) ? (sum - nExt) : sum;
        acc_d = (sub1 >= nExt) ? WIDTH'(sub1 - nExt) : WIDTH'(sub1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MM_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MM_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        n_q     <= n;
                        acc_q   <= '0;
                        cnt_q   <= CW'(WIDTH - 1);
                        state_q <= MM_BUSY;
                    end
                end
                MM_BUSY: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= MM_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= MM_IDLE;
            endcase
        end
    end

    assign p    = acc_q;
    assign done = done_q;

endmodule

// File: rtl/modexp_seq.sv
// Left-to-right square-and-multiply modular exponentiator, c = message^e_key mod n,
// built around one shared sequential modular multiplier.
module modexp_seq
    import rsa_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    modexp_seq_if.slave bus
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    modexp_state_e    state_q;
    logic [WIDTH-1:0] msg_q;
    logic [WIDTH-1:0] e_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] r_q;
    logic [IW-1:0]    bit_q;
    op_e              op_q;
    logic             bad_q;
    logic             ready_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] c_q;
    logic             mmStart_q;
    logic [31:0]      latCnt_q;

    logic [IW-1:0]    msbIdx;
    logic             badLoad;
    logic [WIDTH-1:0] mmB;
    logic [WIDTH-1:0] mmP;
    logic             mmDone;

    always_comb begin
        msbIdx = '0;
        for (int j = 0; j < WIDTH; j++) begin
            if (e_q[j]) msbIdx = IW'(j);
        end
        badLoad = (n_q == '0) || (msg_q >= n_q);
        mmB     = (op_q == OP_SQ) ? r_q : msg_q;
    end

    mod_mult_seq #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mmStart_q),
        .a       (r_q),
        .b       (mmB),
        .n       (n_q),
        .p       (mmP),
        .done    (mmDone)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            msg_q     <= '0;
            e_q       <= '0;
            n_q       <= '0;
            r_q       <= '0;
            bit_q     <= '0;
            op_q      <= OP_SQ;
            bad_q     <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            c_q       <= '0;
            mmStart_q <= 1'b0;
            latCnt_q  <= '0;
        end else begin
            done_q    <= 1'b0;
            mmStart_q <= 1'b0;
            latCnt_q  <= latCnt_q + 32'd1;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        msg_q    <= bus.message;
                        e_q      <= bus.e_key;
                        n_q      <= bus.n;
                        ready_q  <= 1'b0;
                        latCnt_q <= 32'd1;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    bad_q <= badLoad;
                    r_q   <= msg_q;
                    bit_q <= msbIdx - IW'(1);
                    op_q  <= OP_SQ;
                    if (badLoad) begin
                        c_q     <= '0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else if (msbIdx == '0) begin
                        // e is 0 or 1: no multiplications, 1 mod n collapses to 0 when n == 1.
                        c_q     <= e_q[0] ? msg_q : ((n_q == ONE) ? '0 : ONE);
                        err_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        mmStart_q <= 1'b1;
                        state_q   <= S_OP_GO;
                    end
                end
                S_OP_GO: begin
                    state_q <= S_OP_WAIT;
                end
                S_OP_WAIT: begin
                    if (mmDone) begin
                        r_q <= mmP;
                        if (op_q == OP_SQ && e_q[bit_q]) begin
                            op_q      <= OP_MUL;
                            mmStart_q <= 1'b1;
                            state_q   <= S_OP_GO;
                        end else if (bit_q == '0) begin
                            c_q     <= mmP;
                            err_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            bit_q     <= bit_q - IW'(1);
                            op_q      <= OP_SQ;
                            mmStart_q <= 1'b1;
                            state_q   <= S_OP_GO;
                        end
                    end
                end
                S_FIN: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // latCnt_q equals the cycle number since accept, so in FIN it must match the model.
    always_ff @(posedge clk) begin
        if (reset_n && state_q == S_FIN && !bad_q)
            assert (int'(latCnt_q) == modexp_latency(WIDTH, MAX_WIDTH'(e_q)));
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.c     = c_q;

endmodule

// File: tb/tb_modexp_seq.sv
// Self-checking bench for modexp_seq: 16-bit vector table plus handshake/reset
// sequences, and 128-bit random requests against a big-integer model.
module tb_modexp_seq;
    import rsa_pkg::*;

    typedef struct {
        logic [127:0] c;
        logic         err;
        int           lat;
        int           acc;
    } exp_t;

    typedef struct {
        logic [15:0] m;
        logic [15:0] e;
        logic [15:0] nn;
        logic [15:0] c;
        logic        err;
        int          lat;
    } vec_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   compared;
    int   failed;
    exp_t q16[$];
    exp_t q128[$];
    vec_t vecs[13];

    modexp_seq_if #(.WIDTH(16))  bus16();
    modexp_seq_if #(.WIDTH(128)) bus128();

    modexp_seq #(.WIDTH(16)) dut16 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus16)
    );

    modexp_seq #(.WIDTH(128)) dut128 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus128)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
        compared++;
        if (act !== expv) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [127:0] modelExp(input logic [127:0] b, input logic [127:0] e,
                                              input logic [127:0] m);
        logic [255:0] r;
        logic [255:0] x;
        logic [255:0] mm;
        mm = {128'b0, m};
        r  = 256'd1 % mm;
        x  = {128'b0, b} % mm;
        for (int i = 0; i < 128; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[127:0];
    endfunction

    always @(negedge clk) begin
        exp_t x;
        if (reset_n && bus16.done) begin
            if (q16.size() == 0) begin
                compared++;
                failed++;
                $display("[TB] FAIL done16_unexpected: got done=1 expected 0");
            end else begin
                x = q16.pop_front();
                checkOutput("c16", 128'(bus16.c), x.c);
                checkOutput("err16", 128'(bus16.err), 128'(x.err));
                checkOutput("lat16", 128'(cyc - x.acc), 128'(x.lat));
            end
        end
        if (reset_n && bus128.done) begin
            if (q128.size() == 0) begin
                compared++;
                failed++;
                $display("[TB] FAIL done128_unexpected: got done=1 expected 0");
            end else begin
                x = q128.pop_front();
                checkOutput("c128", bus128.c, x.c);
                checkOutput("err128", 128'(bus128.err), 128'(x.err));
                checkOutput("lat128", 128'(cyc - x.acc), 128'(x.lat));
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus16.ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!bus16.ready) begin
            compared++;
            failed++;
            $display("[TB] FAIL ready16_timeout: got ready=0 expected 1");
            return;
        end
        bus16.start   = 1'b1;
        bus16.message = v.m;
        bus16.e_key   = v.e;
        bus16.n       = v.nn;
        q16.push_back('{c: 128'(v.c), err: v.err, lat: v.lat, acc: cyc});
        @(negedge clk);
        bus16.start = 1'b0;
    endtask

    task automatic applyStimulus128(input logic [127:0] m, input logic [127:0] e,
                                    input logic [127:0] nn);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus128.ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!bus128.ready) begin
            compared++;
            failed++;
            $display("[TB] FAIL ready128_timeout: got ready=0 expected 1");
            return;
        end
        bus128.start   = 1'b1;
        bus128.message = m;
        bus128.e_key   = e;
        bus128.n       = nn;
        q128.push_back('{c: modelExp(m, e, nn), err: 1'b0,
                         lat: modexp_latency(128, MAX_WIDTH'(e)), acc: cyc});
        @(negedge clk);
        bus128.start = 1'b0;
    endtask

    task automatic waitDrain(input int bound);
        int t;
        t = 0;
        while ((q16.size() != 0 || q128.size() != 0) && t < bound) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        if (q16.size() != 0 || q128.size() != 0) begin
            compared++;
            failed++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", q16.size() + q128.size());
            q16.delete();
            q128.delete();
        end
    endtask

    initial begin
        logic [127:0] rm;
        logic [127:0] re;
        logic [127:0] rn;
        int t;

        compared = 0;
        failed   = 0;
        vecs[0]  = '{m: 16'd4,     e: 16'd13,    nn: 16'd497,   c: 16'd445,   err: 1'b0, lat: 92};
        vecs[1]  = '{m: 16'd65,    e: 16'd17,    nn: 16'd3233,  c: 16'd2790,  err: 1'b0, lat: 92};
        vecs[2]  = '{m: 16'd2790,  e: 16'd2753,  nn: 16'd3233,  c: 16'd65,    err: 1'b0, lat: 272};
        vecs[3]  = '{m: 16'd5,     e: 16'd0,     nn: 16'd497,   c: 16'd1,     err: 1'b0, lat: 2};
        vecs[4]  = '{m: 16'd0,     e: 16'd0,     nn: 16'd1,     c: 16'd0,     err: 1'b0, lat: 2};
        vecs[5]  = '{m: 16'd7,     e: 16'd1,     nn: 16'd497,   c: 16'd7,     err: 1'b0, lat: 2};
        vecs[6]  = '{m: 16'd500,   e: 16'd13,    nn: 16'd497,   c: 16'd0,     err: 1'b1, lat: 2};
        vecs[7]  = '{m: 16'd3,     e: 16'd5,     nn: 16'd0,     c: 16'd0,     err: 1'b1, lat: 2};
        vecs[8]  = '{m: 16'd496,   e: 16'd2,     nn: 16'd497,   c: 16'd1,     err: 1'b0, lat: 20};
        vecs[9]  = '{m: 16'd0,     e: 16'd5,     nn: 16'd497,   c: 16'd0,     err: 1'b0, lat: 56};
        vecs[10] = '{m: 16'd65534, e: 16'd3,     nn: 16'd65535, c: 16'd65534, err: 1'b0, lat: 38};
        vecs[11] = '{m: 16'd65534, e: 16'd65535, nn: 16'd65535, c: 16'd65534, err: 1'b0, lat: 542};
        vecs[12] = '{m: 16'd4,     e: 16'd13,    nn: 16'd497,   c: 16'd445,   err: 1'b0, lat: 92};

        bus16.start  = 1'b0;
        bus16.message = '0;
        bus16.e_key  = '0;
        bus16.n      = '0;
        bus128.start = 1'b0;
        bus128.message = '0;
        bus128.e_key = '0;
        bus128.n     = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_ready16", 128'(bus16.ready), 128'd1);
        checkOutput("rst_done16", 128'(bus16.done), 128'd0);
        checkOutput("rst_c16", 128'(bus16.c), 128'd0);
        checkOutput("rst_err16", 128'(bus16.err), 128'd0);
        checkOutput("rst_ready128", 128'(bus128.ready), 128'd1);
        checkOutput("rst_c128", bus128.c, 128'd0);

        $display("[TB] 16-bit vector table, back-to-back");
        for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);
        waitDrain(2000);

        $display("[TB] start held high, inputs scrambled after accept");
        t = 0;
        @(negedge clk);
        while (!bus16.ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        bus16.start   = 1'b1;
        bus16.message = 16'd65;
        bus16.e_key   = 16'd17;
        bus16.n       = 16'd3233;
        q16.push_back('{c: 128'd2790, err: 1'b0, lat: 92, acc: cyc});
        @(negedge clk);
        checkOutput("ready_low", 128'(bus16.ready), 128'd0);
        for (int i = 0; i < 40; i++) begin
            bus16.message = 16'($urandom);
            bus16.e_key   = 16'($urandom);
            bus16.n       = 16'($urandom);
            @(negedge clk);
        end
        bus16.start = 1'b0;
        waitDrain(500);
        repeat (10) @(negedge clk);
        checkOutput("c_hold", 128'(bus16.c), 128'd2790);

        $display("[TB] reset during OP_WAIT");
        applyStimulus(vecs[0]);
        repeat (28) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_ready", 128'(bus16.ready), 128'd1);
        checkOutput("abort_done", 128'(bus16.done), 128'd0);
        checkOutput("abort_c", 128'(bus16.c), 128'd0);
        q16.delete();
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(vecs[0]);
        waitDrain(500);

        $display("[TB] 128-bit random requests");
        for (int i = 0; i < 2; i++) begin
            rn = {1'b1, 31'($urandom), $urandom, $urandom, $urandom};
            if (rn[126:0] == '0) rn[0] = 1'b1;
            rm = {$urandom, $urandom, $urandom, $urandom} % rn;
            re = {$urandom, $urandom, $urandom, $urandom};
            if (i == 1) re = {88'b0, 8'($urandom), $urandom};
            applyStimulus128(rm, re, rn);
            waitDrain(40000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
